// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bus bundle for dmem_arbiter.
//               Core side   : C_WE, C_RE, C_ADDR, C_WDATA, C_WSTB -> C_RDATA, C_STALL
//               DMA side    : D_REQ, D_WE, D_ADDR, D_WDATA, D_WSTB -> D_ACK, D_RDATA, D_RVALID
//               Memory side : M_CE, M_ADDR, M_DATAO, M_WSTB <- M_DATAI
//               slave  modport: the arbiter itself.
//               master modport: the surrounding core / DMA / dmem environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
    logic [1:0]  C_WE;
    logic [1:0]  C_RE;
    logic [29:0] C_ADDR;
    logic [31:0] C_WDATA;
    logic [3:0]  C_WSTB;
    logic [31:0] C_RDATA;
    logic        C_STALL;

    logic        D_REQ;
    logic        D_WE;
    logic [29:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [3:0]  D_WSTB;
    logic        D_ACK;
    logic [31:0] D_RDATA;
    logic        D_RVALID;

    logic        M_CE;
    logic [29:0] M_ADDR;
    logic [31:0] M_DATAO;
    logic [3:0]  M_WSTB;
    logic [31:0] M_DATAI;

    modport slave (
        input  C_WE, C_RE, C_ADDR, C_WDATA, C_WSTB,
        output C_RDATA, C_STALL,
        input  D_REQ, D_WE, D_ADDR, D_WDATA, D_WSTB,
        output D_ACK, D_RDATA, D_RVALID,
        output M_CE, M_ADDR, M_DATAO, M_WSTB,
        input  M_DATAI
    );

    modport master (
        output C_WE, C_RE, C_ADDR, C_WDATA, C_WSTB,
        input  C_RDATA, C_STALL,
        output D_REQ, D_WE, D_ADDR, D_WDATA, D_WSTB,
        input  D_ACK, D_RDATA, D_RVALID,
        input  M_CE, M_ADDR, M_DATAO, M_WSTB,
        output M_DATAI
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter for the single data-memory port. The core
//               MEM-stage access has fixed priority; a word-wide secondary
//               master (loader / DMA) gets the port in core-idle cycles.
//               With DMEM_ARB_STARVE_EN defined, a starvation counter forces
//               a DMA grant (stalling the core one cycle) after STARVE_LIMIT
//               consecutive cycles of DMA waiting.
//               Ports : CLK, RSTN (async active-low), bus (dmem_arbiter_if.slave)
//               Params: DMEM_BASE (window base, ADDR[31:20] compared),
//                       STARVE_LIMIT (2..255)
//               Macro : DMEM_ARB_STARVE_EN
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter logic [31:0] DMEM_BASE    = 32'h0010_0000,
    parameter int          STARVE_LIMIT = 16
) (
    input  wire logic      CLK,
    input  wire logic      RSTN,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_DMAZ = 2'd3
    } owner_t;

    // Word addresses are [31:2], so byte-address bits [31:20] sit at [29:18].
    localparam logic [11:0] c_WIN = DMEM_BASE[31:20];

    logic   w_core_req;
    logic   w_core_wr;
    logic   w_dma_hit;
    logic   w_dma_req;
    logic   w_dma_oow;
    logic   w_force;
    logic   w_dma_win;
    logic   w_core_win;
    owner_t r_rd_owner;
    owner_t w_rd_owner_nxt;

    assign w_core_req = ((|bus.C_WE) | (|bus.C_RE)) & (bus.C_ADDR[29:18] == c_WIN);
    assign w_core_wr  = |bus.C_WE;
    assign w_dma_hit  = (bus.D_ADDR[29:18] == c_WIN);
    assign w_dma_req  = bus.D_REQ & w_dma_hit;
    // Out-of-window DMA access is acknowledged without touching the memory.
    assign w_dma_oow  = bus.D_REQ & ~w_dma_hit;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] c_SAT = 8'(STARVE_LIMIT - 1);

    logic [7:0] r_starve_cnt;

    assign w_force = w_dma_req & (r_starve_cnt == c_SAT);

    // Counts consecutive cycles a DMA request was denied; saturates so the
    // force condition stays asserted until the grant clears it.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_starve_cnt <= 8'd0;
        end else if (!w_dma_req || w_dma_win) begin
            r_starve_cnt <= 8'd0;
        end else if (r_starve_cnt != c_SAT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_dma_win  = w_dma_req & (w_force | ~w_core_req);
    assign w_core_win = w_core_req & ~w_force;

    // Memory-side mux: the winner drives the bus, strobes are zero on reads.
    always_comb begin
        bus.M_ADDR  = bus.C_ADDR;
        bus.M_DATAO = bus.C_WDATA;
        bus.M_WSTB  = 4'h0;
        if (w_dma_win) begin
            bus.M_ADDR  = bus.D_ADDR;
            bus.M_DATAO = bus.D_WDATA;
            bus.M_WSTB  = bus.D_WE ? bus.D_WSTB : 4'h0;
        end else if (w_core_win && w_core_wr) begin
            bus.M_WSTB  = bus.C_WSTB;
        end
    end

    // Handshake outputs are gated by RSTN so they are quiet during reset.
    assign bus.M_CE    = RSTN & (w_dma_win | w_core_win);
    assign bus.D_ACK   = RSTN & (w_dma_win | w_dma_oow);
`ifdef DMEM_ARB_STARVE_EN
    assign bus.C_STALL = RSTN & w_core_req & w_force;
`else
    assign bus.C_STALL = 1'b0;
`endif

    // Read-owner tracking. A DMA read (real or out-of-window) takes precedence
    // over a concurrent core read here: C_RDATA is unconditional, so only the
    // DMA needs the owner to qualify its data.
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_dma_win && !bus.D_WE) begin
            w_rd_owner_nxt = OWN_DMA;
        end else if (w_dma_oow && !bus.D_WE) begin
            w_rd_owner_nxt = OWN_DMAZ;
        end else if (w_core_win && !w_core_wr) begin
            w_rd_owner_nxt = OWN_CORE;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    assign bus.D_RDATA  = (r_rd_owner == OWN_DMA) ? bus.M_DATAI : 32'h0;
    assign bus.D_RVALID = (r_rd_owner == OWN_DMA) || (r_rd_owner == OWN_DMAZ);
    assign bus.C_RDATA  = bus.M_DATAI;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter: vector table, directed
//               corner sequences and randomized traffic against a cycle-level
//               reference model with a shadow memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [31:0] c_base  = 32'h0010_0000;
    localparam int          c_limit = 4;
    localparam logic [29:0] c_basew = 30'h0004_0000;
    localparam logic [29:0] c_oow   = 30'h0008_0000;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit c_starve_en = 1'b1;
`else
    localparam bit c_starve_en = 1'b0;
`endif

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    dmem_arbiter_if bus();

    dmem_arbiter #(.DMEM_BASE(c_base), .STARVE_LIMIT(c_limit)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    // Synchronous-read data memory.
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    always @(posedge CLK) begin
        if (bus.M_CE) begin
            bus.M_DATAI <= mem[bus.M_ADDR[9:0]];
            for (int b = 0; b < 4; b++)
                if (bus.M_WSTB[b]) mem[bus.M_ADDR[9:0]][8*b +: 8] <= bus.M_DATAO[8*b +: 8];
        end
    end

    // ------------------------------------------------------------------ model
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
    int          waited;
    logic        exp_dv, exp_cv;
    logic [31:0] exp_dd, exp_cd;
    logic        last_ack, last_stall;
    int          n_pass, n_total;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, wanted %h", nm, act, exp);
    endtask

    function automatic logic in_window(input logic [29:0] a);
        return ((({a, 2'b00}) >> 20) == (c_base >> 20));
    endfunction

    task automatic model_reset();
        waited = 0; exp_dv = 0; exp_cv = 0; exp_dd = 0; exp_cd = 0;
        last_ack = 0; last_stall = 0;
    endtask

    // Called at the negedge: checks the current cycle, then advances the model.
    task automatic model_cycle();
        logic creq, dreq, oow, frc, dwin, cwin, cwr;
        logic [3:0]  ewstb;
        logic [31:0] ewdata;
        logic [29:0] eaddr;
        creq = ((bus.C_WE != 0) || (bus.C_RE != 0)) && in_window(bus.C_ADDR);
        dreq = bus.D_REQ && in_window(bus.D_ADDR);
        oow  = bus.D_REQ && !in_window(bus.D_ADDR);
        frc  = c_starve_en && dreq && (waited >= c_limit - 1);
        dwin = dreq && (frc || !creq);
        cwin = creq && !frc;
        cwr  = (bus.C_WE != 0);
        eaddr  = dwin ? bus.D_ADDR  : bus.C_ADDR;
        ewdata = dwin ? bus.D_WDATA : bus.C_WDATA;
        ewstb  = dwin ? (bus.D_WE ? bus.D_WSTB : 4'h0) : ((cwin && cwr) ? bus.C_WSTB : 4'h0);

        chk("M_CE", 32'(bus.M_CE), 32'(dwin | cwin));
        chk("C_STALL", 32'(bus.C_STALL), 32'(creq & frc));
        chk("D_ACK", 32'(bus.D_ACK), 32'(dwin | oow));
        chk("D_RVALID", 32'(bus.D_RVALID), 32'(exp_dv));
        chk("D_RDATA", bus.D_RDATA, exp_dv ? exp_dd : 32'h0);
        if (exp_cv) chk("C_RDATA", bus.C_RDATA, exp_cd);
        if (dwin || cwin) begin
            chk("M_ADDR", 32'(bus.M_ADDR), 32'(eaddr));
            chk("M_WSTB", 32'(bus.M_WSTB), 32'(ewstb));
            if (ewstb != 0) chk("M_DATAO", bus.M_DATAO, ewdata);
        end

        exp_dv = (dwin || oow) && !bus.D_WE;
        exp_dd = dwin ? ref_mem[bus.D_ADDR[9:0]] : 32'h0;
        exp_cv = cwin && !cwr;
        exp_cd = ref_mem[bus.C_ADDR[9:0]];
        for (int b = 0; b < 4; b++)
            if (ewstb[b]) ref_mem[eaddr[9:0]][8*b +: 8] = ewdata[8*b +: 8];
        if (dreq && !dwin) waited = (waited + 1 > c_limit - 1) ? c_limit - 1 : waited + 1;
        else waited = 0;
        last_ack   = dwin | oow;
        last_stall = creq & frc;
    endtask

    task automatic step();
        @(negedge CLK);
        model_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.C_WE = 0; bus.C_RE = 0; bus.C_ADDR = c_oow; bus.C_WDATA = 0; bus.C_WSTB = 0;
        bus.D_REQ = 0; bus.D_WE = 0; bus.D_ADDR = c_oow; bus.D_WDATA = 0; bus.D_WSTB = 0;
    endtask

    task automatic core_wr(input logic [29:0] a, input logic [31:0] d);
        bus.C_WE = 2'b11; bus.C_RE = 0; bus.C_ADDR = a; bus.C_WDATA = d; bus.C_WSTB = 4'hF;
    endtask

    task automatic core_rd(input logic [29:0] a);
        bus.C_WE = 0; bus.C_RE = 2'b11; bus.C_ADDR = a; bus.C_WSTB = 4'h0;
    endtask

    task automatic dma(input logic we, input logic [29:0] a, input logic [31:0] d);
        bus.D_REQ = 1; bus.D_WE = we; bus.D_ADDR = a; bus.D_WDATA = d; bus.D_WSTB = 4'hF;
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic [1:0] c_we, c_re;
        logic       c_hit, d_req, d_we, d_hit;
        logic       e_ce, e_ack, e_stall;
        logic [3:0] e_wstb;
    } vec_t;

    vec_t vt [9];

    initial begin
        int ack_cyc, stall_cyc;
        n_pass = 0; n_total = 0;
        model_reset();
        idle();

        // Reset: requests present but handshake outputs must stay quiet.
        core_wr(c_basew + 1, 32'h1111_1111);
        dma(1'b0, c_basew + 2, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_M_CE", 32'(bus.M_CE), 0);
        chk("rst_D_ACK", 32'(bus.D_ACK), 0);
        chk("rst_C_STALL", 32'(bus.C_STALL), 0);
        chk("rst_D_RVALID", 32'(bus.D_RVALID), 0);
        chk("rst_D_RDATA", bus.D_RDATA, 0);
        @(posedge CLK); #1;
        idle();
        RSTN = 1;

        //          c_we   c_re   ch d_req dwe dh  ce ack stl wstb
        vt[0] = '{2'b11, 2'b00, 1, 0, 0, 1,  1, 0, 0, 4'hF};
        vt[1] = '{2'b00, 2'b10, 1, 0, 0, 1,  1, 0, 0, 4'h0};
        vt[2] = '{2'b01, 2'b00, 0, 0, 0, 1,  0, 0, 0, 4'h0};
        vt[3] = '{2'b00, 2'b00, 1, 1, 1, 1,  1, 1, 0, 4'h3};
        vt[4] = '{2'b00, 2'b00, 1, 1, 0, 1,  1, 1, 0, 4'h0};
        vt[5] = '{2'b11, 2'b00, 1, 1, 1, 1,  1, 0, 0, 4'hF};
        vt[6] = '{2'b00, 2'b00, 1, 1, 0, 0,  0, 1, 0, 4'h0};
        vt[7] = '{2'b00, 2'b01, 1, 1, 1, 0,  1, 1, 0, 4'h0};
        vt[8] = '{2'b10, 2'b00, 0, 1, 1, 1,  1, 1, 0, 4'h3};
        for (int i = 0; i < 9; i++) begin
            bus.C_WE = vt[i].c_we; bus.C_RE = vt[i].c_re;
            bus.C_ADDR = vt[i].c_hit ? c_basew + 30'(32 + i) : c_oow;
            bus.C_WDATA = 32'hC0DE_0000 + 32'(i); bus.C_WSTB = 4'hF;
            bus.D_REQ = vt[i].d_req; bus.D_WE = vt[i].d_we;
            bus.D_ADDR = vt[i].d_hit ? c_basew + 30'(48 + i) : c_oow + 30'd16;
            bus.D_WDATA = 32'hD0DE_0000 + 32'(i); bus.D_WSTB = 4'h3;
            @(negedge CLK);
            chk($sformatf("vec%0d_ce", i), 32'(bus.M_CE), 32'(vt[i].e_ce));
            chk($sformatf("vec%0d_ack", i), 32'(bus.D_ACK), 32'(vt[i].e_ack));
            chk($sformatf("vec%0d_stall", i), 32'(bus.C_STALL), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d_wstb", i), 32'(bus.M_WSTB), 32'(vt[i].e_wstb));
            model_cycle();
            @(posedge CLK); #1;
            idle();
            step();
        end

        // Core word write then read-back.
        core_wr(30'h0004_0010, 32'hDEAD_BEEF);
        @(negedge CLK);
        chk("core_wr_wstb", 32'(bus.M_WSTB), 32'hF);
        model_cycle(); @(posedge CLK); #1;
        core_rd(30'h0004_0010);
        step();
        idle();
        @(negedge CLK);
        chk("core_rdback", bus.C_RDATA, 32'hDEAD_BEEF);
        model_cycle(); @(posedge CLK); #1;

        // DMA read of a preloaded word.
        core_wr(30'h0004_0040, 32'h1234_5678);
        step();
        idle();
        dma(1'b0, 30'h0004_0040, 32'h0);
        @(negedge CLK);
        chk("dma_rd_ack", 32'(bus.D_ACK), 1);
        model_cycle(); @(posedge CLK); #1;
        idle();
        @(negedge CLK);
        chk("dma_rd_valid", 32'(bus.D_RVALID), 1);
        chk("dma_rd_data", bus.D_RDATA, 32'h1234_5678);
        model_cycle(); @(posedge CLK); #1;

        // Starvation: core busy every cycle while DMA writes.
        core_rd(30'h0004_0001);
        dma(1'b1, 30'h0004_0080, 32'hA5A5_A5A5);
        ack_cyc = 0; stall_cyc = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (bus.D_ACK && ack_cyc == 0) ack_cyc = k;
            if (bus.C_STALL && stall_cyc == 0) stall_cyc = k;
            model_cycle(); @(posedge CLK); #1;
            if (last_ack) bus.D_REQ = 0;
        end
        chk("starve_ack_cycle", ack_cyc, c_starve_en ? 4 : 0);
        chk("starve_stall_cycle", stall_cyc, c_starve_en ? 4 : 0);
        bus.C_WE = 0; bus.C_RE = 0;
        @(negedge CLK);
        if (!c_starve_en) chk("idle_ack", 32'(bus.D_ACK), 1);
        model_cycle(); @(posedge CLK); #1;
        idle();
        core_rd(30'h0004_0080);
        step();
        idle();
        @(negedge CLK);
        chk("starve_rdback", bus.C_RDATA, 32'hA5A5_A5A5);
        model_cycle(); @(posedge CLK); #1;

        // Out-of-window DMA read.
        dma(1'b0, 30'h0008_0000, 32'h0);
        @(negedge CLK);
        chk("oow_ack", 32'(bus.D_ACK), 1);
        chk("oow_ce", 32'(bus.M_CE), 0);
        model_cycle(); @(posedge CLK); #1;
        idle();
        @(negedge CLK);
        chk("oow_valid", 32'(bus.D_RVALID), 1);
        chk("oow_data", bus.D_RDATA, 0);
        model_cycle(); @(posedge CLK); #1;

        // Reset between a DMA read grant and its data.
        dma(1'b0, 30'h0004_0040, 32'h0);
        step();
        idle();
        RSTN = 0;
        #1;
        chk("rstmid_valid_low", 32'(bus.D_RVALID), 0);
        @(posedge CLK); #1;
        RSTN = 1;
        model_reset();
        @(negedge CLK);
        chk("rstmid_valid_after", 32'(bus.D_RVALID), 0);
`ifdef DMEM_ARB_STARVE_EN
        chk("rstmid_starve_cnt", 32'(dut.r_starve_cnt), 0);
`endif
        model_cycle(); @(posedge CLK); #1;

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            if (!last_stall) begin
                case ($urandom_range(0, 3))
                    0: begin bus.C_WE = 0; bus.C_RE = 0; end
                    1: begin
                        bus.C_WE = 2'($urandom_range(1, 3)); bus.C_RE = 0;
                        bus.C_ADDR = c_basew + 30'($urandom_range(0, 15));
                        bus.C_WDATA = $urandom; bus.C_WSTB = 4'($urandom);
                    end
                    2: begin
                        bus.C_WE = 0; bus.C_RE = 2'($urandom_range(1, 3));
                        bus.C_ADDR = c_basew + 30'($urandom_range(0, 15));
                    end
                    default: begin
                        bus.C_WE = 0; bus.C_RE = 2'b11;
                        bus.C_ADDR = c_oow + 30'($urandom_range(0, 15));
                    end
                endcase
            end
            if (!bus.D_REQ || last_ack) begin
                case ($urandom_range(0, 4))
                    0, 1: bus.D_REQ = 0;
                    2, 3: begin
                        bus.D_REQ = 1; bus.D_WE = 1'($urandom);
                        bus.D_ADDR = c_basew + 30'($urandom_range(0, 15));
                        bus.D_WDATA = $urandom; bus.D_WSTB = 4'($urandom);
                    end
                    default: begin
                        bus.D_REQ = 1; bus.D_WE = 1'($urandom);
                        bus.D_ADDR = c_oow + 30'($urandom_range(0, 15));
                        bus.D_WDATA = $urandom; bus.D_WSTB = 4'hF;
                    end
                endcase
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
